// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM menu controller.
package atm_pkg;

  localparam int unsigned NUM_SCREENS = 4;

  localparam logic [1:0] SCR_BALANCE  = 2'd0;
  localparam logic [1:0] SCR_WITHDRAW = 2'd1;
  localparam logic [1:0] SCR_CURRENCY = 2'd2;
  localparam logic [1:0] SCR_TRANSFER = 2'd3;

  typedef enum logic [1:0] {
    StBrowse  = 2'd0,
    StConfirm = 2'd1,
    StRun     = 2'd2,
    StDone    = 2'd3
  } menu_state_e;

  function automatic logic [NUM_SCREENS-1:0] scr_onehot(input logic [1:0] scr);
    return NUM_SCREENS'(1) << scr;
  endfunction

endpackage

// File: rtl/sec_counter.sv
// Saturating tick counter with clear and load; tc flags the tick that reaches MAX.
module sec_counter #(
  parameter int unsigned MAX = 3,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         tc
);

  localparam logic [W-1:0] Max  = W'(MAX);
  localparam logic [W-1:0] Last = W'(MAX - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (tick && (cnt_q != Max)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // Asserted on the tick that completes the count so the FSM reacts one clk later.
  assign tc = tick && !clear && !load && (cnt_q >= Last);

endmodule

// File: rtl/atm_menu_ctrl.sv
// ATM menu sequencer: browse screens, confirm, run and hold the completed operation.
// Optional idle timeout compiled in with MENU_TIMEOUT_EN.
module atm_menu_ctrl
  import atm_pkg::*;
#(
  parameter int unsigned IDLE_SECS = 30,
  parameter int unsigned DONE_HOLD = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       up_p,
  input  logic       down_p,
  input  logic       sel_p,
  input  logic       back_p,
  input  logic       op_done,
  output logic [1:0] screen,
  output logic [3:0] scr_rst,
  output logic       op_start,
  output logic       op_abort,
  output logic       busy,
  output logic [1:0] mstate
);

  menu_state_e state_q, state_d;
  logic [1:0]  screen_q, screen_d;
  logic        op_start_q, op_start_d;
  logic        op_abort_q, op_abort_d;
  logic        restart_q, restart_d;
  logic        hold_all_q;
  logic        done_tc;
  logic        idle_tc;

  sec_counter #(
    .MAX (DONE_HOLD)
  ) u_done_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q != StDone),
    .load     (1'b0),
    .load_val ('0),
    .tick     (tick_1hz),
    .tc       (done_tc)
  );

`ifdef MENU_TIMEOUT_EN
  logic any_btn;
  assign any_btn = up_p | down_p | sel_p | back_p;

  sec_counter #(
    .MAX (IDLE_SECS)
  ) u_idle_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (any_btn || !((state_q == StBrowse) || (state_q == StConfirm))),
    .load     (1'b0),
    .load_val ('0),
    .tick     (tick_1hz),
    .tc       (idle_tc)
  );
`else
  assign idle_tc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBrowse;
      screen_q   <= SCR_BALANCE;
      op_start_q <= 1'b0;
      op_abort_q <= 1'b0;
      restart_q  <= 1'b0;
      hold_all_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      screen_q   <= screen_d;
      op_start_q <= op_start_d;
      op_abort_q <= op_abort_d;
      restart_q  <= restart_d;
      hold_all_q <= 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    screen_d   = screen_q;
    op_start_d = 1'b0;
    op_abort_d = 1'b0;
    unique case (state_q)
      StBrowse: begin
        if (back_p) begin
          state_d = StBrowse;
        end else if (sel_p) begin
          state_d = StConfirm;
        end else if (up_p) begin
          screen_d = screen_q - 2'd1;
        end else if (down_p) begin
          screen_d = screen_q + 2'd1;
        end
      end
      StConfirm: begin
        if (back_p) begin
          state_d = StBrowse;
        end else if (sel_p) begin
          state_d    = StRun;
          op_start_d = 1'b1;
        end
      end
      StRun: begin
        // A finishing operation beats a cancel arriving in the same clk.
        if (op_done) begin
          state_d = StDone;
        end else if (back_p) begin
          state_d    = StBrowse;
          op_abort_d = 1'b1;
        end
      end
      StDone: begin
        if (done_tc) state_d = StBrowse;
      end
      default: state_d = StBrowse;
    endcase
    if (idle_tc) begin
      state_d  = StBrowse;
      screen_d = SCR_BALANCE;
    end
    restart_d = (screen_d != screen_q);
  end

  logic [NUM_SCREENS-1:0] sel_oh;

  always_comb begin
    sel_oh   = scr_onehot(screen_q);
    screen   = screen_q;
    mstate   = state_q;
    op_start = op_start_q;
    op_abort = op_abort_q;
    busy     = (state_q == StRun) || (state_q == StDone);
    scr_rst  = hold_all_q ? '1 : (~sel_oh | (restart_q ? sel_oh : '0));
  end

endmodule

// File: tb/tb_atm_menu_ctrl.sv
// Directed self-checking bench for atm_menu_ctrl (default parameters).
module tb_atm_menu_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       up_p = 1'b0, down_p = 1'b0, sel_p = 1'b0, back_p = 1'b0;
  logic       op_done = 1'b0;
  logic [1:0] screen;
  logic [3:0] scr_rst;
  logic       op_start, op_abort, busy;
  logic [1:0] mstate;

  int compared = 0;
  int mismatched = 0;

  // {up, down, sel, back, op_done, tick}
  localparam logic [5:0] UP   = 6'b100000;
  localparam logic [5:0] DOWN = 6'b010000;
  localparam logic [5:0] SEL  = 6'b001000;
  localparam logic [5:0] BACK = 6'b000100;
  localparam logic [5:0] OPD  = 6'b000010;
  localparam logic [5:0] TICK = 6'b000001;

  atm_menu_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .up_p     (up_p),
    .down_p   (down_p),
    .sel_p    (sel_p),
    .back_p   (back_p),
    .op_done  (op_done),
    .screen   (screen),
    .scr_rst  (scr_rst),
    .op_start (op_start),
    .op_abort (op_abort),
    .busy     (busy),
    .mstate   (mstate)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive the pulse vector for one clk; outputs are sampled after return.
  task automatic press(input logic [5:0] v);
    {up_p, down_p, sel_p, back_p, op_done, tick_1hz} = v;
    step();
    {up_p, down_p, sel_p, back_p, op_done, tick_1hz} = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    compared++; if (scr_rst !== 4'b1111) begin mismatched++; $display("FAIL reset scr_rst: got %b expected 1111", scr_rst); end
    compared++; if (screen !== 2'd0) begin mismatched++; $display("FAIL reset screen: got %0d expected 0", screen); end
    compared++; if (mstate !== 2'd0) begin mismatched++; $display("FAIL reset mstate: got %0d expected 0", mstate); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset busy: got %b expected 0", busy); end
    compared++; if (op_start !== 1'b0) begin mismatched++; $display("FAIL reset op_start: got %b expected 0", op_start); end
    compared++; if (op_abort !== 1'b0) begin mismatched++; $display("FAIL reset op_abort: got %b expected 0", op_abort); end
    rst = 1'b0;
    step();
    compared++; if (scr_rst !== 4'b1110) begin mismatched++; $display("FAIL post-reset scr_rst: got %b expected 1110", scr_rst); end
  endtask

  task automatic test_scroll();
    logic [1:0] exp_scr [5];
    logic [3:0] exp_rst;
    exp_scr = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    for (int i = 0; i < 5; i++) begin
      press(UP);
      compared++; if (screen !== exp_scr[i]) begin mismatched++; $display("FAIL scroll[%0d] screen: got %0d expected %0d", i, screen, exp_scr[i]); end
      compared++; if (scr_rst !== 4'b1111) begin mismatched++; $display("FAIL scroll[%0d] restart scr_rst: got %b expected 1111", i, scr_rst); end
      step();
      exp_rst = 4'b1111 ^ (4'b0001 << exp_scr[i]);
      compared++; if (scr_rst !== exp_rst) begin mismatched++; $display("FAIL scroll[%0d] settled scr_rst: got %b expected %b", i, scr_rst, exp_rst); end
    end
    press(BACK);
    compared++; if (mstate !== 2'd0 || screen !== 2'd3) begin mismatched++; $display("FAIL browse back: got state %0d screen %0d expected 0/3", mstate, screen); end
  endtask

  task automatic test_select();
    press(DOWN);
    compared++; if (screen !== 2'd0) begin mismatched++; $display("FAIL down wrap screen: got %0d expected 0", screen); end
    press(SEL);
    compared++; if (mstate !== 2'd1 || op_start !== 1'b0) begin mismatched++; $display("FAIL confirm: got state %0d op_start %b expected 1/0", mstate, op_start); end
    press(SEL);
    compared++; if (mstate !== 2'd2) begin mismatched++; $display("FAIL run mstate: got %0d expected 2", mstate); end
    compared++; if (op_start !== 1'b1) begin mismatched++; $display("FAIL op_start pulse: got %b expected 1", op_start); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL run busy: got %b expected 1", busy); end
    step();
    compared++; if (op_start !== 1'b0) begin mismatched++; $display("FAIL op_start width: got %b expected 0", op_start); end
  endtask

  task automatic test_done_priority();
    press(BACK | OPD);
    compared++; if (mstate !== 2'd3) begin mismatched++; $display("FAIL done priority mstate: got %0d expected 3", mstate); end
    compared++; if (op_abort !== 1'b0) begin mismatched++; $display("FAIL done priority op_abort: got %b expected 0", op_abort); end
    step();
    compared++; if (op_abort !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL done hold: got op_abort %b busy %b expected 0/1", op_abort, busy); end
    press(UP);
    compared++; if (screen !== 2'd0 || mstate !== 2'd3) begin mismatched++; $display("FAIL done ignores up: got screen %0d state %0d expected 0/3", screen, mstate); end
    press(TICK);
    step();
    press(TICK);
    step();
    compared++; if (mstate !== 2'd3) begin mismatched++; $display("FAIL done after 2 ticks: got %0d expected 3", mstate); end
    press(TICK);
    compared++; if (mstate !== 2'd0 || busy !== 1'b0) begin mismatched++; $display("FAIL done exit: got state %0d busy %b expected 0/0", mstate, busy); end
  endtask

  task automatic test_run_abort();
    press(SEL);
    press(SEL);
    press(UP);
    compared++; if (screen !== 2'd0 || mstate !== 2'd2) begin mismatched++; $display("FAIL run ignores up: got screen %0d state %0d expected 0/2", screen, mstate); end
    press(DOWN);
    press(SEL);
    compared++; if (screen !== 2'd0 || op_start !== 1'b0) begin mismatched++; $display("FAIL run ignores down/sel: got screen %0d op_start %b expected 0/0", screen, op_start); end
    press(BACK);
    compared++; if (op_abort !== 1'b1) begin mismatched++; $display("FAIL abort pulse: got %b expected 1", op_abort); end
    compared++; if (mstate !== 2'd0 || busy !== 1'b0) begin mismatched++; $display("FAIL abort state: got state %0d busy %b expected 0/0", mstate, busy); end
    step();
    compared++; if (op_abort !== 1'b0) begin mismatched++; $display("FAIL abort width: got %b expected 0", op_abort); end
  endtask

  task automatic test_priority();
    press(SEL | UP);
    compared++; if (mstate !== 2'd1 || screen !== 2'd0) begin mismatched++; $display("FAIL sel over up: got state %0d screen %0d expected 1/0", mstate, screen); end
    press(UP);
    compared++; if (mstate !== 2'd1 || screen !== 2'd0) begin mismatched++; $display("FAIL confirm ignores up: got state %0d screen %0d expected 1/0", mstate, screen); end
    press(BACK | SEL);
    compared++; if (mstate !== 2'd0 || op_start !== 1'b0) begin mismatched++; $display("FAIL back over sel: got state %0d op_start %b expected 0/0", mstate, op_start); end
    press(OPD);
    compared++; if (mstate !== 2'd0) begin mismatched++; $display("FAIL op_done in browse: got %0d expected 0", mstate); end
    press(UP | DOWN);
    compared++; if (screen !== 2'd3) begin mismatched++; $display("FAIL up over down: got %0d expected 3", screen); end
    press(DOWN);
    compared++; if (screen !== 2'd0) begin mismatched++; $display("FAIL down from 3: got %0d expected 0", screen); end
  endtask

  task automatic test_rst_mid_run();
    press(DOWN);
    press(DOWN);
    press(SEL);
    press(SEL);
    compared++; if (mstate !== 2'd2 || screen !== 2'd2) begin mismatched++; $display("FAIL pre-reset run: got state %0d screen %0d expected 2/2", mstate, screen); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    compared++; if (scr_rst !== 4'b1111) begin mismatched++; $display("FAIL mid-run reset scr_rst: got %b expected 1111", scr_rst); end
    compared++; if (screen !== 2'd0 || mstate !== 2'd0) begin mismatched++; $display("FAIL mid-run reset state: got screen %0d state %0d expected 0/0", screen, mstate); end
    compared++; if (op_abort !== 1'b0) begin mismatched++; $display("FAIL mid-run reset op_abort: got %b expected 0", op_abort); end
    step();
    compared++; if (scr_rst !== 4'b1110 || op_abort !== 1'b0) begin mismatched++; $display("FAIL after mid-run reset: got scr_rst %b op_abort %b expected 1110/0", scr_rst, op_abort); end
  endtask

  task automatic test_timeout();
    press(DOWN);
    press(DOWN);
    press(SEL);
    compared++; if (mstate !== 2'd1 || screen !== 2'd2) begin mismatched++; $display("FAIL timeout setup: got state %0d screen %0d expected 1/2", mstate, screen); end
`ifdef MENU_TIMEOUT_EN
    repeat (29) press(TICK);
    compared++; if (mstate !== 2'd1) begin mismatched++; $display("FAIL 29 ticks: got state %0d expected 1", mstate); end
    press(UP);
    repeat (29) press(TICK);
    compared++; if (mstate !== 2'd1 || screen !== 2'd2) begin mismatched++; $display("FAIL idle restart: got state %0d screen %0d expected 1/2", mstate, screen); end
    press(TICK);
    compared++; if (mstate !== 2'd0 || screen !== 2'd0) begin mismatched++; $display("FAIL idle timeout: got state %0d screen %0d expected 0/0", mstate, screen); end
    compared++; if (scr_rst !== 4'b1111) begin mismatched++; $display("FAIL timeout restart: got %b expected 1111", scr_rst); end
    step();
    compared++; if (scr_rst !== 4'b1110) begin mismatched++; $display("FAIL timeout settled: got %b expected 1110", scr_rst); end
`else
    repeat (30) press(TICK);
    compared++; if (mstate !== 2'd1 || screen !== 2'd2) begin mismatched++; $display("FAIL no timeout: got state %0d screen %0d expected 1/2", mstate, screen); end
    press(BACK);
    compared++; if (mstate !== 2'd0) begin mismatched++; $display("FAIL confirm back: got %0d expected 0", mstate); end
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scroll();
    test_select();
    test_done_priority();
    test_run_abort();
    test_priority();
    test_rst_mid_run();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
